keypad_param_entry: RTL and testbench
=====================================

// Module: keypad_param_entry
// PURPOSE
//  - Sits directly downstream of the 4x4 matrix keypad scanner.
//  - Turns its key_value/key_valid stream into committed numeric settings for the analyzer, e.g. gain, threshold, band select, refresh.
//  - Keys A-D choose one of four parameter registers. Digits build a BCD entry buffer; '*' deletes, '#' enters.
//  - On '#' the BCD buffer is converted serially to binary, clamped, and written to the chosen register.
// PARAMETERS
//  DIGITS          4           max decimal digits per entry (1..6)
//  VAL_W           14          width of each parameter register
//  MAX_VAL         9999        clamp ceiling for committed values
//  RESET_VAL       0           value loaded into all four registers at reset
//  TIMEOUT_CYCLES  36000000    idle-abort time in clk cycles (3 s at 12 MHz); used only with the macro
// PORTS
//  clk           in   1          system clock
//  rst           in   1          synchronous reset, active-high
//  key_value     in   4          upstream key code: 0-9 digit, 10 '*', 11 '#', 12-15 A-D
//  key_valid     in   1          1-cycle strobe qualifying key_value
//  param0..3     out  VAL_W      committed parameter registers
//  param_commit  out  1          1-cycle pulse when a register is written
//  commit_sel    out  2          index of the register written; held until the next commit
//  entry_active  out  1          high while in ENTRY/CONVERT/WRITE
//  entry_sel     out  2          register currently being edited
//  entry_bcd     out  4*DIGITS   entry buffer; nibble 0 is the least-significant (last typed) digit
//  entry_cnt     out  3          number of digits in the buffer (0..DIGITS)
//  err_pulse     out  1          1-cycle pulse: overflow digit, clamp, or timeout abort
// BEHAVIOUR
//  - Clock and reset: one clock, clk; reset is synchronous and active-high, port rst.
//  - Reset values:
//    - param0..3 = RESET_VAL.
//    - commit_sel = 0, entry_sel = 0, entry_bcd = 0, entry_cnt = 0.
//    - entry_active = 0, param_commit = 0, err_pulse = 0.
//    - FSM in IDLE.
//  - Reset mid-entry or mid-CONVERT aborts with no commit and no err_pulse.
//  - FSM states: IDLE, ENTRY, CONVERT, WRITE. Keys are acted on only in cycles where key_valid = 1.
//  - IDLE:
//    - A-D (12-15): entry_sel <= code-12, buffer cleared, go to ENTRY.
//    - Digits, '*' and '#' are ignored silently.
//  - ENTRY, digit d:
//    - If entry_cnt < DIGITS: shift entry_bcd left one nibble, nibble 0 <= d, entry_cnt++.
//    - If entry_cnt = DIGITS: buffer unchanged, err_pulse.
//  - ENTRY, '*':
//    - If entry_cnt > 0: shift right one nibble (top nibble <= 0), entry_cnt--.
//    - If entry_cnt = 0: abort to IDLE.
//  - ENTRY, '#':
//    - If entry_cnt = 0: abort to IDLE with no commit.
//    - Otherwise go to CONVERT.
//  - ENTRY, A-D: reselect entry_sel and clear the buffer; stay in ENTRY.
//  - CONVERT:
//    - Runs exactly DIGITS cycles, most-significant nibble first: acc <= acc*10 + nibble.
//    - acc is 4*DIGITS bits wide; no overflow is possible. Leading zero nibbles are harmless.
//  - WRITE (1 cycle):
//    - val = (acc > MAX_VAL) ? MAX_VAL : acc, truncated to VAL_W.
//    - param[entry_sel] <= val, commit_sel <= entry_sel.
//    - err_pulse if the value was clamped.
//    - Buffer cleared, then go to IDLE.
//  - Latency: if '#' is sampled in cycle T, the new param value and param_commit both appear at T+DIGITS+2.
//  - key_valid during CONVERT or WRITE is dropped silently. The upstream key rate makes this harmless.
//  - Pulses: param_commit and err_pulse are registered and one cycle wide; they can coincide.
//  - entry_active = 1 in ENTRY, CONVERT and WRITE.
// CONFIGURATION
//  - Macro KEYPAD_ENTRY_TIMEOUT_EN defined:
//    - A counter clears on every key_valid in ENTRY and counts while in ENTRY.
//    - At TIMEOUT_CYCLES-1 the FSM aborts to IDLE: buffer cleared, err_pulse, no commit.
//    - The counter is frozen and cleared in all other states.
//  - Macro not defined: no counter is built, ENTRY waits indefinitely, and TIMEOUT_CYCLES is unused.
// TESTING
//  1. Reset: assert rst 2 cycles -> params = 0, all pulses 0, entry_active = 0, entry_cnt = 0.
//  2. Keys 12,1,2,3,11 -> param0 = 123, commit_sel = 0, param_commit high once at T+6 (DIGITS = 4); param1..3 unchanged.
//  3. Keys 13,9,9,9,9,9 -> err_pulse on the 5th 9, entry_bcd = 16'h9999; then 11 with MAX_VAL = 5000 -> param1 = 5000, err_pulse with commit.
//  4. Keys 14,4,5,10,7,11 -> param2 = 47. Keys 15,10 -> IDLE, no commit. Keys 15,11 -> IDLE, no commit.
//  5. Keys 12,8, assert rst during CONVERT -> param0 = 0, no param_commit. Digits typed in IDLE -> no state change.
//  6. Macro on, TIMEOUT_CYCLES = 100: keys 12,5, then idle 100 cycles -> entry_active = 0, err_pulse, param0 unchanged.
//     Macro off: still in ENTRY after 1000 cycles.

Source files
------------

// File: rtl/keypad_param_entry_if.sv
// Key stream from the matrix keypad scanner into the parameter entry block.
interface keypad_param_entry_if;
  logic [3:0] key_value;
  logic       key_valid;

  modport master (output key_value, key_valid);
  modport slave  (input  key_value, key_valid);
endinterface

// File: rtl/keypad_param_entry.sv
// Keypad parameter entry: A-D select a register, digits fill a BCD buffer, '#' converts and commits.
// Optional idle-abort timer is built only when KEYPAD_ENTRY_TIMEOUT_EN is defined.
module keypad_param_entry #(
  parameter int DIGITS         = 4,
  parameter int VAL_W          = 14,
  parameter int MAX_VAL        = 9999,
  parameter int RESET_VAL      = 0,
  parameter int TIMEOUT_CYCLES = 36000000
) (
  input  logic                  clk,
  input  logic                  rst,
  keypad_param_entry_if.slave   key,
  output logic [VAL_W-1:0]      param0,
  output logic [VAL_W-1:0]      param1,
  output logic [VAL_W-1:0]      param2,
  output logic [VAL_W-1:0]      param3,
  output logic                  param_commit,
  output logic [1:0]            commit_sel,
  output logic                  entry_active,
  output logic [1:0]            entry_sel,
  output logic [4*DIGITS-1:0]   entry_bcd,
  output logic [2:0]            entry_cnt,
  output logic                  err_pulse
);

  localparam int BW = 4*DIGITS;
  localparam logic [BW-1:0] MAX_B     = BW'(MAX_VAL);
  localparam logic [2:0]    DIG3      = 3'(DIGITS);
  localparam logic [2:0]    STEP_LAST = 3'(DIGITS-1);

  typedef enum logic [1:0] {IDLE, ENTRY, CONVERT, WRITE} state_t;

  state_t                  state, state_n;
  logic [BW-1:0]           bcd_n, conv_sr, conv_sr_n, acc, acc_n;
  logic [2:0]              cnt_n, step, step_n;
  logic [1:0]              sel_n, csel_n;
  logic [3:0][VAL_W-1:0]   prm, prm_n;
  logic                    commit_n, err_n;
  logic                    is_digit, is_star, is_sel;
  logic                    clamp_hit, timeout;
  logic [3:0]              nib;
  logic [VAL_W-1:0]        wval;

  assign is_digit = key.key_value < 4'd10;
  assign is_star  = key.key_value == 4'd10;
  assign is_sel   = key.key_value[3:2] == 2'b11;
  assign nib      = conv_sr[BW-1 -: 4];
  assign clamp_hit = acc > MAX_B;
  assign wval     = clamp_hit ? VAL_W'(MAX_B) : VAL_W'(acc);

`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] to_cnt;

  // Restarts on every key so the limit measures time since the last keystroke.
  always_ff @(posedge clk) begin
    if (rst || state != ENTRY || key.key_valid) to_cnt <= '0;
    else                                        to_cnt <= to_cnt + 1'b1;
  end
  assign timeout = (to_cnt == TW'(TIMEOUT_CYCLES-1));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    bcd_n     = entry_bcd;
    cnt_n     = entry_cnt;
    sel_n     = entry_sel;
    conv_sr_n = conv_sr;
    acc_n     = acc;
    step_n    = step;
    prm_n     = prm;
    csel_n    = commit_sel;
    commit_n  = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (key.key_valid && is_sel) begin
          sel_n   = key.key_value[1:0];
          bcd_n   = '0;
          cnt_n   = '0;
          state_n = ENTRY;
        end
      end
      ENTRY: begin
        if (key.key_valid) begin
          if (is_sel) begin
            sel_n = key.key_value[1:0];
            bcd_n = '0;
            cnt_n = '0;
          end else if (is_digit) begin
            if (entry_cnt < DIG3) begin
              bcd_n = BW'({entry_bcd, key.key_value});
              cnt_n = entry_cnt + 3'd1;
            end else begin
              err_n = 1'b1;
            end
          end else if (is_star) begin
            if (entry_cnt != 3'd0) begin
              bcd_n = entry_bcd >> 4;
              cnt_n = entry_cnt - 3'd1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            if (entry_cnt == 3'd0) begin
              state_n = IDLE;
            end else begin
              conv_sr_n = entry_bcd;
              acc_n     = '0;
              step_n    = '0;
              state_n   = CONVERT;
            end
          end
        end else if (timeout) begin
          bcd_n   = '0;
          cnt_n   = '0;
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      CONVERT: begin
        // acc never exceeds 10^DIGITS-1, so BW-bit arithmetic cannot wrap.
        acc_n     = acc * BW'(10) + BW'(nib);
        conv_sr_n = conv_sr << 4;
        step_n    = step + 3'd1;
        if (step == STEP_LAST) state_n = WRITE;
      end
      WRITE: begin
        prm_n[entry_sel] = wval;
        csel_n   = entry_sel;
        commit_n = 1'b1;
        err_n    = clamp_hit;
        bcd_n    = '0;
        cnt_n    = '0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      entry_bcd    <= '0;
      entry_cnt    <= '0;
      entry_sel    <= '0;
      conv_sr      <= '0;
      acc          <= '0;
      step         <= '0;
      prm          <= {4{VAL_W'(RESET_VAL)}};
      commit_sel   <= '0;
      param_commit <= 1'b0;
      err_pulse    <= 1'b0;
    end else begin
      state        <= state_n;
      entry_bcd    <= bcd_n;
      entry_cnt    <= cnt_n;
      entry_sel    <= sel_n;
      conv_sr      <= conv_sr_n;
      acc          <= acc_n;
      step         <= step_n;
      prm          <= prm_n;
      commit_sel   <= csel_n;
      param_commit <= commit_n;
      err_pulse    <= err_n;
    end
  end

  assign entry_active = (state != IDLE);
  assign param0 = prm[0];
  assign param1 = prm[1];
  assign param2 = prm[2];
  assign param3 = prm[3];

endmodule

// File: tb/tb_keypad_param_entry.sv
// Directed bench for keypad_param_entry with a decimal-level reference model checked every cycle.
module tb_keypad_param_entry;
  localparam int DIGITS    = 4;
  localparam int VAL_W     = 14;
  localparam int MAX_VAL   = 5000;
  localparam int RESET_VAL = 0;
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 36000000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  keypad_param_entry_if kif();
  logic [VAL_W-1:0]    param0, param1, param2, param3;
  logic                param_commit, entry_active, err_pulse;
  logic [1:0]          commit_sel, entry_sel;
  logic [4*DIGITS-1:0] entry_bcd;
  logic [2:0]          entry_cnt;

  keypad_param_entry #(
    .DIGITS(DIGITS), .VAL_W(VAL_W), .MAX_VAL(MAX_VAL),
    .RESET_VAL(RESET_VAL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .key(kif),
    .param0(param0), .param1(param1), .param2(param2), .param3(param3),
    .param_commit(param_commit), .commit_sel(commit_sel),
    .entry_active(entry_active), .entry_sel(entry_sel),
    .entry_bcd(entry_bcd), .entry_cnt(entry_cnt), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model: keypad semantics at the level of a list of typed digits.
  int  m_params[4];
  int  m_csel, m_sel, mode, busy_left, pend, idle_cnt, k, v;
  int  q[$];
  bit  pend_clamp, exp_commit, exp_err, m_valid;

  always @(posedge clk) begin
    exp_commit = 0;
    exp_err    = 0;
    if (rst) begin
      m_valid = 1;
      for (int i = 0; i < 4; i++) m_params[i] = RESET_VAL;
      m_csel = 0; m_sel = 0; q.delete(); mode = 0; idle_cnt = 0;
    end else if (m_valid) begin
      if (mode == 2) begin
        busy_left--;
        if (busy_left == 0) begin
          m_params[m_sel] = pend;
          m_csel = m_sel;
          exp_commit = 1;
          exp_err = pend_clamp;
          q.delete();
          mode = 0;
        end
      end else if (kif.key_valid) begin
        k = int'(kif.key_value);
        if (k >= 12) begin
          m_sel = k - 12; q.delete(); mode = 1; idle_cnt = 0;
        end else if (mode == 1) begin
          idle_cnt = 0;
          if (k < 10) begin
            if (q.size() < DIGITS) q.push_back(k);
            else exp_err = 1;
          end else if (k == 10) begin
            if (q.size() > 0) void'(q.pop_back());
            else mode = 0;
          end else begin
            if (q.size() == 0) mode = 0;
            else begin
              v = 0;
              foreach (q[i]) v = v * 10 + q[i];
              pend_clamp = (v > MAX_VAL);
              pend = pend_clamp ? MAX_VAL : v;
              busy_left = DIGITS + 1;
              mode = 2;
            end
          end
        end
      end else if (mode == 1) begin
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
        idle_cnt++;
        if (idle_cnt == TO) begin
          q.delete(); mode = 0; exp_err = 1;
        end
`endif
      end
    end
  end

  logic [4*DIGITS-1:0] exp_bcd;
  int commit_total = 0;
  int both_total   = 0;
  int commit_cyc   = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      exp_bcd = '0;
      foreach (q[i]) exp_bcd[4*(q.size()-1-i) +: 4] = 4'(q[i]);
      chk("param0", param0, m_params[0]);
      chk("param1", param1, m_params[1]);
      chk("param2", param2, m_params[2]);
      chk("param3", param3, m_params[3]);
      chk("param_commit", param_commit, exp_commit);
      chk("err_pulse", err_pulse, exp_err);
      chk("commit_sel", commit_sel, m_csel);
      chk("entry_active", entry_active, mode != 0);
      chk("entry_sel", entry_sel, m_sel);
      chk("entry_cnt", entry_cnt, q.size());
      chk("entry_bcd", entry_bcd, exp_bcd);
      if (param_commit === 1'b1) begin
        commit_total++;
        commit_cyc = cyc;
        if (err_pulse === 1'b1) both_total++;
      end
    end
  end

  int press_cyc = 0;

  task automatic press(input int kv);
    @(negedge clk);
    kif.key_value = 4'(kv);
    kif.key_valid = 1'b1;
    press_cyc = cyc;
    @(negedge clk);
    kif.key_valid = 1'b0;
  endtask

  task automatic seq(input int ks[]);
    foreach (ks[i]) press(ks[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    kif.key_value = 4'd0;
    kif.key_valid = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("rst_param0", param0, 0);
    chk("rst_active", entry_active, 0);
    chk("rst_cnt", entry_cnt, 0);
    chk("rst_commit", param_commit, 0);

    // A, 1 2 3, '#'
    seq('{12, 1, 2, 3, 11});
    idle(8);
    chk("lit_param0_123", param0, 123);
    chk("lit_commit_sel0", commit_sel, 0);
    chk("lit_latency", commit_cyc - press_cyc, 6);
    chk("lit_commits_1", commit_total, 1);
    chk("lit_param1_untouched", param1, 0);

    // B, five 9s: fifth overflows
    seq('{13, 9, 9, 9, 9});
    press(9);
    chk("lit_overflow_err", err_pulse, 1);
    chk("lit_bcd_9999", entry_bcd, 16'h9999);
    press(11);
    idle(8);
    chk("lit_param1_clamp", param1, 5000);
    chk("lit_commit_err_coincide", both_total, 1);

    // C, 4 5 '*' 7 '#'
    seq('{14, 4, 5, 10, 7, 11});
    idle(8);
    chk("lit_param2_47", param2, 47);
    seq('{15, 10});
    idle(2);
    chk("lit_star_abort", entry_active, 0);
    seq('{15, 11});
    idle(2);
    chk("lit_hash_abort", entry_active, 0);
    chk("lit_commits_3", commit_total, 3);

    // clamp boundary: 5000 exact, then 5001
    seq('{15, 5, 0, 0, 0, 11});
    idle(8);
    chk("lit_param3_5000", param3, 5000);
    chk("lit_no_clamp_err", both_total, 1);
    seq('{15, 5, 0, 0, 1, 11});
    idle(8);
    chk("lit_clamp_5001", both_total, 2);

    // leading zeros, then a key dropped during conversion
    seq('{12, 0, 0, 4, 2, 11});
    idle(8);
    chk("lit_param0_42", param0, 42);
    seq('{13, 7, 11});
    press(3);
    idle(8);
    chk("lit_param1_7", param1, 7);
    chk("lit_commits_7", commit_total, 7);

    // reset during conversion
    seq('{12, 8, 11});
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(10);
    chk("lit_rst_param0", param0, 0);
    chk("lit_rst_no_commit", commit_total, 7);
    seq('{5, 3});
    idle(1);
    chk("lit_idle_digits", entry_active, 0);
    chk("lit_idle_cnt", entry_cnt, 0);

    // idle in ENTRY
    seq('{12, 5});
`ifdef KEYPAD_ENTRY_TIMEOUT_EN
    idle(100);
    chk("lit_timeout_err", err_pulse, 1);
    chk("lit_timeout_idle", entry_active, 0);
    chk("lit_timeout_param0", param0, 0);
`else
    idle(1000);
    chk("lit_no_timeout", entry_active, 1);
    chk("lit_no_timeout_cnt", entry_cnt, 1);
`endif
    seq('{10, 10});
    idle(3);
    chk("lit_final_idle", entry_active, 0);
    chk("lit_final_commits", commit_total, 7);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
